div_iter_r2: RTL and testbench
==============================

// Module: div_iter_r2
// PURPOSE
//  Iterative radix-2 restoring divider: the responder side of the EX-stage start/ready divide handshake.
//  - EX holds start high while a DIV/DIVU/REM/REMU (or W variant) sits in EX and ready is low.
//    EX stalls on divOn & ~ready.
//  - This block returns the quotient and remainder with RISC-V semantics, then pulses ready for one cycle.
// PARAMETERS
//  XLEN  64  operand/result width; word mode operates on the low 32 bits
// PORTS
//  clock      in   1     system clock, all state on posedge
//  reset      in   1     synchronous, active-high
//  start      in   1     request; level, held by EX until ready
//  is_signed  in   1     1: signed div/rem, 0: unsigned
//  is_word    in   1     1: DIVW/DIVUW/REMW/REMUW (use a[31:0], b[31:0])
//  a          in   XLEN  dividend, stable while start=1
//  b          in   XLEN  divisor, stable while start=1
//  ready      out  1     one-cycle pulse: q/r/error valid
//  error      out  1     divide-by-zero flag, valid with ready
//  q          out  XLEN  quotient
//  r          out  XLEN  remainder
// BEHAVIOUR
//  Reset: state=IDLE; ready=0, error=0, q=0, r=0. Reset mid-operation drops the request; no ready is produced.
//  Operands: word mode sign-extends (is_signed) or zero-extends a[31:0]/b[31:0] before the divide; N=32.
//    Otherwise N=XLEN.
//  FSM IDLE -> CALC -> FIX -> DONE -> IDLE:
//   IDLE:
//    - start=1 accepts the request.
//    - Latches the magnitudes |a|, |b| (signed mode only).
//    - Latches quotient sign = sa^sb and remainder sign = sa.
//    - Loads count=N.
//    - b==0 (after extension) goes straight to DONE.
//   CALC: one quotient bit per cycle.
//    - rem = {rem, dvd[msb]}; if rem >= |b|: rem -= |b| and the bit is 1.
//    - Count decrements; at count==1 go to FIX.
//   FIX:
//    - Negate q if the quotient sign is set; negate r if the remainder sign is set.
//    - Word mode: sign-extend both from bit 31, for signed and unsigned alike.
//   DONE: ready=1 for exactly one cycle, then IDLE.
//  Latency: start accepted in cycle 0 -> ready in cycle N+2; divide-by-zero -> ready in cycle 1.
//  Divide by zero:
//    - error=1, q=all ones, r=extended dividend.
//    - Word mode: r=sext(a[31:0]).
//  Signed overflow: MIN/-1 gives q=MIN, r=0, error=0. This falls out of the unsigned magnitude path.
//    Word mode: q=sext(32'h80000000).
//  Abort: start=0 in CALC or FIX -> IDLE next cycle; no ready; q/r unchanged.
//    This handles a flushed EX.
//  start during DONE or a ready cycle is ignored. EX drops start when it sees ready, so back-to-back divides
//    restart from IDLE the following cycle.
//  q, r, error hold their last values after ready until the next completed operation. error clears when the next
//    request is accepted.
//  ready never asserts in a cycle in which start was not continuously high since acceptance.
// TESTING
//  - unsigned a=100, b=7, start held -> ready at cycle 66, q=14, r=2, error=0; ready low at cycle 67.
//  - signed a=-7, b=2 -> q=-3 (0xFFFF_FFFF_FFFF_FFFD), r=-1; a=7, b=-2 -> q=-3, r=1.
//  - b=0, a=0x1234 -> ready at cycle 1, error=1, q=0xFFFF_FFFF_FFFF_FFFF, r=0x1234.
//  - signed a=0x8000_0000_0000_0000, b=-1 -> q=0x8000_0000_0000_0000, r=0, error=0.
//  - word: DIVUW a=0xFFFF_FFFF, b=1 -> q=0xFFFF_FFFF_FFFF_FFFF, ready at cycle 34;
//    REMW a=-7, b=3 -> r=-1.
//  - drop start at cycle 10, restart 100/7 two cycles later -> single ready, q=14, r=2;
//    assert reset mid-CALC -> no ready, outputs 0.

Source files
------------

// File: rtl/div_iter_r2.sv
// rtl/div_iter_r2.sv - iterative radix-2 restoring divider, responder side of the EX start/ready handshake
//
// Purpose: returns quotient and remainder with RISC-V DIV/DIVU/REM/REMU (and W variant)
// semantics. A request is held on start until ready pulses for one cycle.
//
// Ports:
//   clock      in   1     system clock, all state on posedge
//   reset      in   1     synchronous, active-high
//   start      in   1     request level, held by EX until ready
//   is_signed  in   1     1: signed div/rem, 0: unsigned
//   is_word    in   1     1: word op on a[31:0]/b[31:0], results sign-extended from bit 31
//   a          in   XLEN  dividend, stable while start=1
//   b          in   XLEN  divisor, stable while start=1
//   ready      out  1     one-cycle pulse, q/r/error valid
//   error      out  1     divide-by-zero flag
//   q          out  XLEN  quotient
//   r          out  XLEN  remainder

module div_iter_r2 #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            is_signed,
   input  logic            is_word,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            ready,
   output logic            error,
   output logic [XLEN-1:0] q,
   output logic [XLEN-1:0] r
);

   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] dvd;     // dividend magnitude shifting out, quotient bits shifting in
   logic [XLEN-1:0] dvs;     // divisor magnitude
   logic [XLEN-1:0] rem;     // partial remainder
   logic            q_neg;
   logic            r_neg;
   logic            word;

   // operand extension and magnitudes
   logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, dvd_init, zero_rem;
   logic            sa, sb;
   logic [CW-1:0]   n_bits;

   always_comb begin
      ext_a = a;
      ext_b = b;
      if (is_word) begin
         ext_a = {{(XLEN-32){is_signed & a[31]}}, a[31:0]};
         ext_b = {{(XLEN-32){is_signed & b[31]}}, b[31:0]};
      end
      sa    = is_signed & ext_a[XLEN-1];
      sb    = is_signed & ext_b[XLEN-1];
      mag_a = sa ? -ext_a : ext_a;
      mag_b = sb ? -ext_b : ext_b;
      // Word mode left-aligns the 32-bit magnitude so CALC always consumes from bit XLEN-1.
      dvd_init = is_word ? (mag_a << (XLEN-32)) : mag_a;
      n_bits   = is_word ? CW'(32) : CW'(XLEN);
      // Divide-by-zero remainder: word mode always sign-extends a[31:0], even for REMUW.
      zero_rem = is_word ? {{(XLEN-32){a[31]}}, a[31:0]} : a;
   end

   // one restoring step
   logic [XLEN:0]   rem_sh, rem_sub;
   logic            take;

   always_comb begin
      rem_sh  = {rem, dvd[XLEN-1]};
      rem_sub = rem_sh - {1'b0, dvs};
      // rem_sh < 2*dvs, so a non-negative difference always fits in XLEN bits
      // and the top bit is a clean borrow flag.
      take    = ~rem_sub[XLEN];
   end

   // sign fix-up
   logic [XLEN-1:0] q_sgn, r_sgn, q_fix, r_fix;

   always_comb begin
      q_sgn = q_neg ? -dvd : dvd;
      r_sgn = r_neg ? -rem : rem;
      q_fix = q_sgn;
      r_fix = r_sgn;
      if (word) begin
         q_fix = {{(XLEN-32){q_sgn[31]}}, q_sgn[31:0]};
         r_fix = {{(XLEN-32){r_sgn[31]}}, r_sgn[31:0]};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         ready <= 1'b0;
         error <= 1'b0;
         q     <= '0;
         r     <= '0;
         count <= '0;
         dvd   <= '0;
         dvs   <= '0;
         rem   <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         word  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready <= 1'b0;
               if (start) begin
                  word  <= is_word;
                  q_neg <= sa ^ sb;
                  r_neg <= sa;
                  dvs   <= mag_b;
                  dvd   <= dvd_init;
                  rem   <= '0;
                  count <= n_bits;
                  if (ext_b == '0) begin
                     error <= 1'b1;
                     q     <= '1;
                     r     <= zero_rem;
                     ready <= 1'b1;
                     state <= DONE;
                  end else begin
                     error <= 1'b0;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (!start) begin
                  state <= IDLE;
               end else begin
                  rem   <= take ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
                  dvd   <= {dvd[XLEN-2:0], take};
                  count <= count - CW'(1);
                  if (count == CW'(1)) state <= FIX;
               end
            end
            FIX: begin
               if (!start) begin
                  state <= IDLE;
               end else begin
                  q     <= q_fix;
                  r     <= r_fix;
                  ready <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               // start is ignored here; EX drops it on seeing ready
               ready <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter_r2.sv
// tb/tb_div_iter_r2.sv - scoreboard testbench for div_iter_r2

module tb_div_iter_r2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic        is_word = 1'b0;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        ready;
   logic        error;
   logic [63:0] q;
   logic [63:0] r;

   div_iter_r2 #(.XLEN(64)) dut (
      .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
      .is_word(is_word), .a(a), .b(b), .ready(ready), .error(error), .q(q), .r(r)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      logic        e;
      int          lat;
      int          t0;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;

   task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // monitor: compare every ready pulse against the head of the scoreboard
   always @(negedge clock) begin
      if (!reset && ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready at cycle %0d got=1 want=0", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check64({e.name, "_q"}, q, e.q);
            check64({e.name, "_r"}, r, e.r);
            check64({e.name, "_err"}, {63'b0, error}, {63'b0, e.e});
            check64({e.name, "_lat"}, 64'(cyc - e.t0), 64'(e.lat));
         end
      end
   end

   task automatic issue(input string name, input logic sgn, input logic wrd,
                        input logic [63:0] aa, input logic [63:0] bb,
                        input logic [63:0] eq, input logic [63:0] er,
                        input logic ee, input int lat);
      exp_t e;
      bit seen;
      @(negedge clock);
      is_signed = sgn;
      is_word   = wrd;
      a         = aa;
      b         = bb;
      start     = 1'b1;
      e.q = eq; e.r = er; e.e = ee; e.lat = lat; e.t0 = cyc; e.name = name;
      exp_q.push_back(e);
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (ready) begin
            seen = 1;
            break;
         end
      end
      start = 1'b0;
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout got=no_ready want=ready", name);
      end
      @(negedge clock);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      check64("reset_ready", {63'b0, ready}, 64'd0);
      check64("reset_error", {63'b0, error}, 64'd0);
      check64("reset_q", q, 64'd0);
      check64("reset_r", r, 64'd0);
      reset = 1'b0;

      issue("divu_100_7", 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 66);
      issue("div_m7_2", 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 0, 66);
      issue("div_7_m2", 1, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
            64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 0, 66);
      issue("divz", 0, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 1);
      issue("ovf", 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 64'd0, 0, 66);
      issue("divuw", 0, 1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 34);
      issue("remw", 1, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3,
            64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0, 34);
      issue("ovfw", 1, 1, 64'h8000_0000, 64'hFFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 64'd0, 0, 34);
      issue("divzw", 0, 1, 64'h8000_0000, 64'h1_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1);
      issue("divu_big", 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
            64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 66);

      // abort mid-CALC: no ready, outputs keep the previous result
      @(negedge clock);
      is_signed = 0; is_word = 0; a = 64'd100; b = 64'd7; start = 1'b1;
      repeat (10) @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      check64("abort_q_hold", q, 64'h7FFF_FFFF_FFFF_FFFF);
      check64("abort_r_hold", r, 64'd1);
      check64("abort_err_hold", {63'b0, error}, 64'd0);
      issue("restart_100_7", 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 66);

      // error clears on the next accepted request
      issue("divz2", 1, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, 1);
      issue("after_divz", 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 66);

      // reset mid-CALC: no ready, outputs cleared
      @(negedge clock);
      a = 64'd100; b = 64'd7; start = 1'b1;
      repeat (20) @(negedge clock);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      check64("rst_mid_q", q, 64'd0);
      check64("rst_mid_r", r, 64'd0);
      check64("rst_mid_err", {63'b0, error}, 64'd0);
      repeat (80) @(negedge clock);
      issue("post_reset", 0, 0, 64'd1000, 64'd33, 64'd30, 64'd10, 0, 66);

      repeat (5) @(negedge clock);
      check64("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
